// File: rtl/pipeline_pkg.sv
// Shared types and constants for the stage arbiter pipeline slice.
package pipeline_pkg;
  localparam int NUM_W    = 5;
  localparam int MAX_NREQ = 8;

  typedef logic [NUM_W-1:0] num_t;

  // Bits needed to index v entries; never less than 1.
  function automatic int clog2(input int v);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) w = i + 1;
    end
    return w;
  endfunction
endpackage

// File: rtl/tag_fifo.sv
// Synchronous FIFO holding the requester tag of every transaction in flight.
// FORMAL adds occupancy and overflow assertions.
module tag_fifo
  import pipeline_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly log2(DEPTH) bits, so they wrap without explicit compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

`ifdef FORMAL
  a_count_max: assert property (@(posedge clk) disable iff (reset) count <= FULL_CNT);
  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));
`endif
endmodule

// File: rtl/stage_arbiter.sv
// Round-robin arbiter sharing one pipeline stage among NREQ requesters, with in-order
// result routing via a tag FIFO. ARB_STATS_EN adds saturating per-requester grant counters.
module stage_arbiter
  import pipeline_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*NUM_W-1:0] req_num,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output num_t                  issue_num,
  input  logic                  ret_valid,
  output logic                  ret_ready,
  input  num_t                  ret_num,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output num_t                  rsp_num
`ifdef ARB_STATS_EN
  ,
  output logic [NREQ*8-1:0]     grant_count
`endif
);
  localparam int TW = clog2(NREQ);
  localparam logic [TW-1:0] LAST = TW'(NREQ - 1);

  logic [TW-1:0] ptr;
  logic [TW-1:0] gidx;
  logic [TW-1:0] tag_head;
  logic          grant;
  logic          load_ok;
  logic          tag_full;
  logic          tag_empty;
  logic          tag_pop;

  // No look-ahead on a same-cycle pop: a full FIFO blocks the grant outright.
  assign load_ok = !reset && (!issue_valid || issue_ready) && !tag_full;

  always_comb begin
    grant = 1'b0;
    gidx  = '0;
    if (load_ok) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!grant && req_valid[(int'(ptr) + k) % NREQ]) begin
          grant = 1'b1;
          gidx  = TW'((int'(ptr) + k) % NREQ);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gidx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid <= 1'b0;
      issue_num   <= '0;
      ptr         <= LAST;
    end else if (grant) begin
      issue_valid <= 1'b1;
      issue_num   <= req_num[int'(gidx)*NUM_W +: NUM_W];
      ptr         <= gidx;
    end else if (issue_ready) begin
      issue_valid <= 1'b0;
    end
  end

  tag_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TW)
  ) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (grant),
    .push_data (gidx),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  assign ret_ready = !reset && !tag_empty && rsp_ready[tag_head];
  assign rsp_num   = ret_num;
  assign tag_pop   = ret_valid && ret_ready;

  always_comb begin
    rsp_valid = '0;
    if (!reset && ret_valid && !tag_empty) rsp_valid[tag_head] = 1'b1;
  end

`ifdef ARB_STATS_EN
  logic [7:0] cnt [NREQ];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else if (grant && cnt[gidx] != 8'hFF) begin
      cnt[gidx] <= cnt[gidx] + 8'd1;
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NREQ; i++) grant_count[i*8 +: 8] = cnt[i];
  end
`endif

`ifdef FORMAL
  a_ready_onehot0: assert property (@(posedge clk) $onehot0(req_ready));
  a_no_ret_empty: assert property (@(posedge clk) !(ret_ready && tag_empty));
  a_issue_stable: assert property (@(posedge clk) disable iff (reset)
    (issue_valid && !issue_ready) |=> $stable(issue_num));
`endif
endmodule

// File: tb/tb_stage_arbiter.sv
// Self-checking bench for stage_arbiter: an adder stage model plus a result scoreboard.
module tb_stage_arbiter;
  import pipeline_pkg::*;

  localparam int NREQ  = 2;
  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*NUM_W-1:0] req_num;
  logic                  issue_valid;
  logic                  issue_ready;
  num_t                  issue_num;
  logic                  ret_valid;
  logic                  ret_ready;
  num_t                  ret_num;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  num_t                  rsp_num;
  num_t                  num0;
  num_t                  num1;
`ifdef ARB_STATS_EN
  logic [NREQ*8-1:0]     grant_count;
`endif

  assign req_num = {num1, num0};

  stage_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_num     (req_num),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_num   (issue_num),
    .ret_valid   (ret_valid),
    .ret_ready   (ret_ready),
    .ret_num     (ret_num),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_num     (rsp_num)
`ifdef ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] tag;
    num_t       num;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   grants_seen = 0;
  logic stage_en = 1'b0;
  logic sb_en = 1'b0;
  num_t stq[$];
  exp_t expq[$];

  // One clock: observe transfers just before the edge, then drive the stage model.
  task automatic tick();
    exp_t e;
    num_t dummy;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        grants_seen++;
        if (sb_en) begin
          e.tag = 4'(i);
          e.num = req_num[i*NUM_W +: NUM_W] + 5'd1;
          expq.push_back(e);
        end
      end
    end
    if (sb_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          checks++;
          if (expq.size() == 0) begin
            failures++;
            $display("FAIL rsp_unexpected: requester %0d got %0d, nothing outstanding", i, rsp_num);
          end else begin
            e = expq.pop_front();
            if (i != int'(e.tag) || rsp_num !== e.num) begin
              failures++;
              $display("FAIL rsp_route: got req %0d num %0d, expected req %0d num %0d",
                       i, rsp_num, e.tag, e.num);
            end
          end
        end
      end
    end
    if (stage_en) begin
      if (ret_valid && ret_ready && stq.size() > 0) dummy = stq.pop_front();
      if (issue_valid && issue_ready) stq.push_back(issue_num);
    end
    @(posedge clk);
    #1;
    if (stage_en) begin
      ret_valid = (stq.size() > 0);
      ret_num   = (stq.size() > 0) ? num_t'(stq[0] + 5'd1) : '0;
    end
  endtask

  task automatic clear_inputs();
    req_valid   = '0;
    num0        = '0;
    num1        = '0;
    issue_ready = 1'b0;
    ret_valid   = 1'b0;
    ret_num     = '0;
    rsp_ready   = '0;
  endtask

  task automatic do_reset();
    expq.delete();
    stq.delete();
    ret_valid = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    expq.delete();
    stq.delete();
    ret_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset       = 1'b1;
    req_valid   = 2'b11;
    issue_ready = 1'b1;
    rsp_ready   = 2'b11;
    ret_valid   = 1'b1;
    #2;
    checks++;
    if (req_ready !== 2'b00 || ret_ready !== 1'b0 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL reset_forced: req_ready=%b ret_ready=%b rsp_valid=%b, expected 00 0 00",
               req_ready, ret_ready, rsp_valid);
    end
    tick();
    tick();
    clear_inputs();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (issue_valid !== 1'b0 || req_ready !== 2'b00 || rsp_valid !== 2'b00 || ret_ready !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle c%0d: issue_valid=%b req_ready=%b rsp_valid=%b ret_ready=%b, expected all 0",
                 c, issue_valid, req_ready, rsp_valid, ret_ready);
      end
      tick();
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_ready;
    num_t       exp_num;
    clear_inputs();
    stage_en    = 1'b1;
    sb_en       = 1'b1;
    issue_ready = 1'b1;
    rsp_ready   = 2'b11;
    req_valid   = 2'b11;
    num0        = 5'd1;
    num1        = 5'd2;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_num   = (k % 2 == 0) ? 5'd1 : 5'd2;
      #1;
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL alt_grant k%0d: req_ready=%b, expected %b", k, req_ready, exp_ready);
      end
      tick();
      checks++;
      if (issue_valid !== 1'b1 || issue_num !== exp_num) begin
        failures++;
        $display("FAIL alt_issue k%0d: issue_valid=%b issue_num=%0d, expected 1 %0d",
                 k, issue_valid, issue_num, exp_num);
      end
    end
    req_valid = '0;
    for (int c = 0; c < 8; c++) tick();
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL alt_drain: %0d results still outstanding, expected 0", expq.size());
    end
    stage_en = 1'b0;
    sb_en    = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    clear_inputs();
    do_reset();
    req_valid = 2'b01;
    num0      = 5'd7;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL bp_first_grant: req_ready=%b, expected 01", req_ready);
    end
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00 || issue_valid !== 1'b1 || issue_num !== 5'd7) begin
        failures++;
        $display("FAIL bp_slot_busy c%0d: req_ready=%b issue_valid=%b issue_num=%0d, expected 00 1 7",
                 c, req_ready, issue_valid, issue_num);
      end
      tick();
    end
    issue_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (req_ready[0]) n++;
      tick();
    end
    checks++;
    if (n != 3) begin
      failures++;
      $display("FAIL bp_fill_grants: %0d grants before full, expected 3", n);
    end
    ret_valid = 1'b1;
    ret_num   = 5'd9;
    rsp_ready = 2'b01;
    #1;
    checks++;
    if (ret_ready !== 1'b1 || rsp_valid !== 2'b01 || rsp_num !== 5'd9 || req_ready !== 2'b00) begin
      failures++;
      $display("FAIL bp_full_pop: ret_ready=%b rsp_valid=%b rsp_num=%0d req_ready=%b, expected 1 01 9 00",
               ret_ready, rsp_valid, rsp_num, req_ready);
    end
    tick();
    ret_valid = 1'b0;
    rsp_ready = '0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL bp_resume: req_ready=%b, expected 01", req_ready);
    end
    tick();
    req_valid = '0;
  endtask

  task automatic test_return_order();
    clear_inputs();
    do_reset();
    issue_ready = 1'b1;
    req_valid   = 2'b10;
    num1        = 5'd1;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      failures++;
      $display("FAIL ro_grant_r1: req_ready=%b, expected 10", req_ready);
    end
    tick();
    req_valid = 2'b01;
    num0      = 5'd2;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL ro_grant_r0: req_ready=%b, expected 01", req_ready);
    end
    tick();
    req_valid = '0;
    ret_valid = 1'b1;
    ret_num   = 5'd2;
    rsp_ready = 2'b00;
    #1;
    checks++;
    if (rsp_valid !== 2'b10 || rsp_num !== 5'd2 || ret_ready !== 1'b0) begin
      failures++;
      $display("FAIL ro_first_stall: rsp_valid=%b rsp_num=%0d ret_ready=%b, expected 10 2 0",
               rsp_valid, rsp_num, ret_ready);
    end
    tick();
    #1;
    rsp_ready = 2'b10;
    #1;
    checks++;
    if (rsp_valid !== 2'b10 || ret_ready !== 1'b1) begin
      failures++;
      $display("FAIL ro_first_accept: rsp_valid=%b ret_ready=%b, expected 10 1", rsp_valid, ret_ready);
    end
    tick();
    ret_num   = 5'd3;
    rsp_ready = 2'b01;
    #1;
    checks++;
    if (rsp_valid !== 2'b01 || rsp_num !== 5'd3 || ret_ready !== 1'b1) begin
      failures++;
      $display("FAIL ro_second: rsp_valid=%b rsp_num=%0d ret_ready=%b, expected 01 3 1",
               rsp_valid, rsp_num, ret_ready);
    end
    tick();
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || ret_ready !== 1'b0) begin
      failures++;
      $display("FAIL ro_empty_ret: rsp_valid=%b ret_ready=%b, expected 00 0", rsp_valid, ret_ready);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    do_reset();
    issue_ready = 1'b1;
    req_valid   = 2'b11;
    for (int c = 0; c < 3; c++) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL rm_reset_ready: req_ready=%b, expected 00", req_ready);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (issue_valid !== 1'b0) begin
      failures++;
      $display("FAIL rm_slot_cleared: issue_valid=%b, expected 0", issue_valid);
    end
    ret_valid = 1'b1;
    rsp_ready = 2'b11;
    #1;
    checks++;
    if (ret_ready !== 1'b0 || rsp_valid !== 2'b00) begin
      failures++;
      $display("FAIL rm_tags_cleared: ret_ready=%b rsp_valid=%b, expected 0 00", ret_ready, rsp_valid);
    end
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rm_priority_r0: req_ready=%b, expected 01", req_ready);
    end
    tick();
    clear_inputs();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    int exp_cnt;
    clear_inputs();
    stage_en    = 1'b1;
    sb_en       = 1'b1;
    issue_ready = 1'b1;
    rsp_ready   = 2'b11;
    num1        = 5'd4;
    do_reset();
    grants_seen = 0;
    req_valid   = 2'b10;
    for (int c = 0; c < 300; c++) tick();
    req_valid = '0;
    for (int c = 0; c < 6; c++) tick();
    exp_cnt = (grants_seen > 255) ? 255 : grants_seen;
    checks++;
    if (int'(grant_count[15:8]) != exp_cnt || grant_count[7:0] !== 8'd0) begin
      failures++;
      $display("FAIL stats_saturate: grant_count[1]=%0d grant_count[0]=%0d, expected %0d 0",
               grant_count[15:8], grant_count[7:0], exp_cnt);
    end
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL stats_drain: %0d results outstanding, expected 0", expq.size());
    end
    stage_en = 1'b0;
    sb_en    = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_alternate();
    test_backpressure();
    test_return_order();
    test_reset_mid();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
